// File: rtl/vector_pkg.sv
// Shared vector-pipeline definitions: element geometry, register-file
// addressing and the store-unit state encoding.
package vector_pkg;

    localparam int ELEM_W   = 16;
    localparam int NUM_ELEM = 16;
    localparam int VREG_W   = ELEM_W * NUM_ELEM;
    localparam int REG_AW   = 3;

    typedef enum logic [1:0] {
        IDLE,
        LATCH,
        WRITE,
        DONE
    } vst_state_t;

endpackage

// File: rtl/vst_addr_gen.sv
// Element address generator for the vector store unit. Loads base and stride
// when a store is accepted and advances by the stride on every element
// handshake. Addresses wrap modulo 2^MEM_AW.
module vst_addr_gen
    import vector_pkg::*;
#(
    parameter int MEM_AW = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [MEM_AW-1:0] base,
    input  logic [MEM_AW-1:0] stride,
    output logic [MEM_AW-1:0] addr
);

    logic [MEM_AW-1:0] stride_q;

    // Capture base/stride on start, then accumulate the stride per accepted write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr     <= '0;
            stride_q <= '0;
        end else if (load) begin
            addr     <= base;
            stride_q <= stride;
        end else if (step) begin
            addr     <= addr + stride_q;
        end
    end

endmodule

// File: rtl/vector_store_unit.sv
// Vector store unit: reads one vector register once into a snapshot buffer,
// then streams its elements to data memory over a valid/ready handshake and
// pulses done after the last element is accepted.
// Optional feature: define VST_STRIDE_EN to add a 'stride' input; otherwise
// consecutive elements go to consecutive word addresses.
module vector_store_unit
#(
    parameter int ELEM_W   = vector_pkg::ELEM_W,
    parameter int NUM_ELEM = vector_pkg::NUM_ELEM,
    parameter int MEM_AW   = 16,
    parameter int REG_AW   = vector_pkg::REG_AW
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [REG_AW-1:0]          vreg_sel,
    input  logic [MEM_AW-1:0]          base_addr,
`ifdef VST_STRIDE_EN
    input  logic [MEM_AW-1:0]          stride,
`endif
    output logic                       busy,
    output logic                       done,
    output logic [REG_AW-1:0]          rf_rd_addr,
    input  logic [ELEM_W*NUM_ELEM-1:0] rf_rd_data,
    output logic [MEM_AW-1:0]          mem_addr,
    output logic [ELEM_W-1:0]          mem_wdata,
    output logic                       mem_we,
    input  logic                       mem_ready
);

    import vector_pkg::*;

    localparam int               IDX_W    = $clog2(NUM_ELEM);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEM - 1);

    vst_state_t        state_q, state_d;
    logic [IDX_W-1:0]  idx_q;
    logic [ELEM_W-1:0] snap [NUM_ELEM];
    logic [MEM_AW-1:0] cur_addr;
    logic [MEM_AW-1:0] stride_w;
    logic              accept;
    logic              load;

    assign load   = (state_q == IDLE) && start;
    assign accept = mem_we && mem_ready;

`ifdef VST_STRIDE_EN
    assign stride_w = stride;
`else
    assign stride_w = {{(MEM_AW-1){1'b0}}, 1'b1};
`endif

    vst_addr_gen #(
        .MEM_AW (MEM_AW)
    ) u_addr_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .step   (accept),
        .base   (base_addr),
        .stride (stride_w),
        .addr   (cur_addr)
    );

    // State, element index and register-file read address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            rf_rd_addr <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                rf_rd_addr <= vreg_sel;
                idx_q      <= '0;
            end else if (accept && (idx_q != LAST_IDX)) begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    // Snapshot of the whole register, taken once so later RF writes cannot leak in.
    always_ff @(posedge clk) begin
        if (state_q == LATCH) begin
            for (int i = 0; i < NUM_ELEM; i++) begin
                snap[i] <= rf_rd_data[i*ELEM_W +: ELEM_W];
            end
        end
    end

    // Next-state and handshake outputs; address/data are forced to zero outside WRITE.
    always_comb begin
        state_d   = state_q;
        busy      = 1'b1;
        done      = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) state_d = LATCH;
            end
            LATCH: begin
                state_d = WRITE;
            end
            WRITE: begin
                mem_we    = 1'b1;
                mem_addr  = cur_addr;
                mem_wdata = snap[idx_q];
                if (mem_ready && (idx_q == LAST_IDX)) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_vector_store_unit.sv
// Scoreboard bench for vector_store_unit: stimulus pushes expected writes and
// done cycles into queues; a negedge monitor pops and compares them.
module tb_vector_store_unit;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic [2:0]          vreg_sel = '0;
    logic [15:0]         base_addr = '0;
`ifdef VST_STRIDE_EN
    logic [15:0]         stride = 16'd1;
`endif
    logic                busy, done, mem_we;
    logic [2:0]          rf_rd_addr;
    logic [255:0]        rf_rd_data;
    logic [15:0]         mem_addr, mem_wdata;
    logic                mem_ready = 1'b1;

    logic [255:0]        rf [8];
    assign rf_rd_data = rf[rf_rd_addr];

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   done_q[$];

    int nvec = 0;
    int nmis = 0;
    int cyc = 0;
    int start_cyc = 0;
    int stall_mode = 0;

    vector_store_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .vreg_sel   (vreg_sel),
        .base_addr  (base_addr),
`ifdef VST_STRIDE_EN
        .stride     (stride),
`endif
        .busy       (busy),
        .done       (done),
        .rf_rd_addr (rf_rd_addr),
        .rf_rd_data (rf_rd_data),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_ready  (mem_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nmis++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc - start_cyc);
        end
    endtask

    // Ready pattern: cycles 2-4 and 12-13 of a store are stalled in backpressure mode.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            mem_ready = !(stall_mode == 1 && ((cyc - start_cyc) inside {2, 3, 4, 12, 13}));
        end
    end

    // Monitor: accepted writes, stall stability, done pulses.
    logic        was_stall = 1'b0;
    logic [15:0] held_addr, held_data;
    always @(negedge clk) begin
        int   k;
        exp_t e;
        k = cyc - start_cyc;
        if (!rst_n) begin
            was_stall = 1'b0;
        end else begin
            if (was_stall) begin
                chk("stall_addr_stable", 32'(mem_addr), 32'(held_addr));
                chk("stall_data_stable", 32'(mem_wdata), 32'(held_data));
                chk("stall_we_held", 32'(mem_we), 32'd1);
            end
            if (mem_we && mem_ready) begin
                if (exp_q.size() == 0) begin
                    nvec++;
                    nmis++;
                    $display("FAIL unexpected_write: got addr %h data %h, expected no write", mem_addr, mem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_addr", 32'(mem_addr), 32'(e.addr));
                    chk("write_data", 32'(mem_wdata), 32'(e.data));
                    if (e.cyc >= 0) chk("write_cycle", 32'(k), 32'(e.cyc));
                end
            end
            was_stall = mem_we && !mem_ready;
            held_addr = mem_addr;
            held_data = mem_wdata;
            if (done) begin
                if (done_q.size() == 0) begin
                    nvec++;
                    nmis++;
                    $display("FAIL unexpected_done: got done at cycle %0d, expected none", k);
                end else begin
                    chk("done_cycle", 32'(k), 32'(done_q.pop_front()));
                    chk("busy_in_done", 32'(busy), 32'd1);
                end
            end
        end
    end

    function automatic logic [255:0] mk_vec(input logic [15:0] b, input logic [15:0] step);
        logic [255:0] v;
        for (int i = 0; i < 16; i++) v[16*i +: 16] = b + 16'(i) * step;
        return v;
    endfunction

    task automatic do_start(input logic [2:0] vr, input logic [15:0] b);
        @(negedge clk);
        vreg_sel  = vr;
        base_addr = b;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        start_cyc = cyc - 1;
    endtask

    // Queue the expected writes of a store and launch it.
    task automatic run_store(input logic [2:0] vr, input logic [15:0] b, input logic [15:0] s,
                             input logic [255:0] vec, input bit timed, input int n_el, input int done_cyc);
        exp_t        e;
        logic [15:0] a;
        rf[vr] = vec;
        a = b;
        for (int i = 0; i < n_el; i++) begin
            e.addr = a;
            e.data = vec[16*i +: 16];
            e.cyc  = timed ? 2 + i : -1;
            exp_q.push_back(e);
            a = a + s;
        end
        if (done_cyc >= 0) done_q.push_back(done_cyc);
`ifdef VST_STRIDE_EN
        stride = s;
`endif
        do_start(vr, b);
    endtask

    task automatic wait_cycle(input int k);
        while (cyc - start_cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || done_q.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk({name, "_pending"}, 32'(exp_q.size() + done_q.size()), 32'd0);
        exp_q.delete();
        done_q.delete();
        repeat (2) @(posedge clk);
        #1;
        chk({name, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_done"}, 32'(done), 32'd0);
        chk({name, "_we"}, 32'(mem_we), 32'd0);
        chk({name, "_addr"}, 32'(mem_addr), 32'd0);
        chk({name, "_wdata"}, 32'(mem_wdata), 32'd0);
        chk({name, "_rf_addr"}, 32'(rf_rd_addr), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rf[i] = '0;
        #1;
        chk_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Basic store: v3 elements 0x1000+i, base 0x0040, writes in cycles 2-17, done 18.
        run_store(3'd3, 16'h0040, 16'd1, mk_vec(16'h1000, 16'd1), 1'b1, 16, 18);
        #1;
        chk("busy_cycle1", 32'(busy), 32'd1);
        chk("rf_rd_addr", 32'(rf_rd_addr), 32'd3);
        wait_drain("basic");

        // Backpressure: stalls in cycles 2-4 and on element 7 for two cycles, done 23.
        stall_mode = 1;
        run_store(3'd6, 16'h0200, 16'd1, mk_vec(16'h5A00, 16'd1), 1'b0, 16, 23);
        wait_drain("backpressure");
        stall_mode = 0;

        // Wrap: base 0xFFFE -> 0xFFFE, 0xFFFF, 0x0000 .. 0x000D.
        run_store(3'd1, 16'hFFFE, 16'd1, mk_vec(16'hB000, 16'h0101), 1'b1, 16, 18);
        wait_drain("wrap");

        // Snapshot and ignored starts: RF changes from cycle 2, start pulses in cycles 5 and 18.
        run_store(3'd3, 16'h0300, 16'd1, mk_vec(16'h1000, 16'd1), 1'b1, 16, 18);
        wait_cycle(2);
        rf[3] = mk_vec(16'hDEAD, 16'd3);
        wait_cycle(5);
        vreg_sel  = 3'd5;
        base_addr = 16'h7000;
        start     = 1'b1;
        wait_cycle(6);
        start = 1'b0;
        wait_cycle(18);
        start = 1'b1;
        wait_cycle(19);
        start = 1'b0;
        wait_drain("snapshot");
        repeat (20) @(posedge clk);

        // Reset abort in cycle 9: elements 0-6 only, no done, outputs zero at once.
        run_store(3'd2, 16'h0400, 16'd1, mk_vec(16'h3300, 16'd1), 1'b1, 7, -1);
        wait_cycle(9);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("abort");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort_pending", 32'(exp_q.size()), 32'd0);
        run_store(3'd4, 16'h0500, 16'd1, mk_vec(16'h4400, 16'd1), 1'b1, 16, 18);
        wait_drain("after_abort");

`ifdef VST_STRIDE_EN
        // Stride 4 from 0x0100 -> 0x0100, 0x0104 .. 0x013C.
        run_store(3'd7, 16'h0100, 16'd4, mk_vec(16'h6000, 16'd1), 1'b1, 16, 18);
        wait_drain("stride");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/vector_store_unit.md
# vector_store_unit

Streams one 256-bit vector register to data memory as 16 sequential 16-bit element writes. Sits between the vector register file read port and the data-memory write port, on the store path of the vector pipeline. It reads the selected register once, snapshots it into an internal buffer, then issues element writes with a valid/ready handshake. It pulses `done` when the last element is accepted.

## Interface
Parameters:
- `ELEM_W`, 16, element width in bits
- `NUM_ELEM`, 16, elements per vector register (`ELEM_W*NUM_ELEM` = 256)
- `MEM_AW`, 16, memory word-address width
- `REG_AW`, 3, register-file address width (8 vector registers)

Ports:
- `clk`  in  1  clock, all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  store request, sampled only in IDLE
- `vreg_sel`  in  REG_AW  source vector register, sampled with `start`
- `base_addr`  in  MEM_AW  word address of element 0, sampled with `start`
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse after the last element is accepted
- `rf_rd_addr`  out  REG_AW  registered read address to the register file
- `rf_rd_data`  in  256  combinational register-file read data for `rf_rd_addr`
- `mem_addr`  out  MEM_AW  element write address
- `mem_wdata`  out  ELEM_W  element write data
- `mem_we`  out  1  write valid
- `mem_ready`  in  1  memory accepts the write this cycle

## Operation
- States: IDLE, LATCH, WRITE, DONE.
- IDLE, `start`=1:
  - capture `base_addr`
  - drive `rf_rd_addr` <= `vreg_sel`
  - clear the element counter
  - go to LATCH.
- LATCH: load all 256 bits of `rf_rd_data` into the snapshot buffer. Go to WRITE.
- WRITE:
  - `mem_we`=1
  - `mem_wdata` = buffer element `idx`
  - `mem_addr` = base + `idx`
- Element `idx` occupies bits `[16*idx+15 : 16*idx]`.
- On `mem_we && mem_ready`:
  - if `idx`==15: go to DONE
  - otherwise increment `idx`.
- DONE: `done`=1 for one cycle, `mem_we`=0. Return to IDLE.
- Handshake:
  - `mem_addr` and `mem_wdata` are held stable while `mem_we`=1 and `mem_ready`=0.
  - `mem_we` never drops before acceptance.
- Address arithmetic is modulo 2^MEM_AW. base 0xFFFE writes 0xFFFE, 0xFFFF, 0x0000, … 0x000D.
- Register-file writes after LATCH do not affect the store in progress, because it is served from the snapshot.
- `start` outside IDLE is ignored. It is not queued.
- `start` in the DONE cycle is ignored. The earliest new start is sampled in the following IDLE cycle.
- `rst_n` low mid-operation aborts the store immediately:
  - no `done`
  - no further writes
  - outputs take their reset values.

## Timing
- Reset values: `busy`=0, `done`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `rf_rd_addr`=0, state IDLE, `idx`=0.
- `start` sampled at edge E0:
  - LATCH during cycle 1
  - first `mem_we` in cycle 2.
- With `mem_ready` tied high:
  - writes occur in cycles 2–17
  - `done` occurs in cycle 18
  - back to IDLE in cycle 19
  - 19 cycles from start to the next possible start.
- Each `mem_ready`=0 cycle in WRITE adds exactly one cycle of latency.
- `busy` is high in cycles 1–18.
- `done` and `busy` are both high in the DONE cycle.

## Configuration
- `VST_STRIDE_EN` defined:
  - adds input port `stride` [MEM_AW-1:0], sampled with `start`
  - element address = base + `idx`*stride, modulo 2^MEM_AW, computed by accumulation (next address = current + stride).
  - stride 0 writes all 16 elements to `base_addr`, in order.
- Undefined: the port is absent and the stride is fixed at 1.

## Structure
- Shared package `vector_pkg`:
  - `ELEM_W`, `NUM_ELEM`, `VREG_W`(256), `REG_AW`
  - state enum `vst_state_t` {IDLE, LATCH, WRITE, DONE}.
- Sub-module `vst_addr_gen`: holds base/current address, stride, and the increment on handshake. Keeps the stride option isolated from the FSM.

## Test plan
- Basic store:
  - v3 = element i holds 0x1000+i, base 0x0040, `mem_ready`=1
  - -> writes (0x0040+i, 0x1000+i) for i=0..15 in cycles 2–17
  - -> `done` in cycle 18.
- Backpressure: `mem_ready` low in cycles 2–4 and on element 7 for 2 cycles -> addr/data stable while stalled, `done` in cycle 23, no duplicate or skipped element.
- Wrap: base 0xFFFE -> addresses 0xFFFE, 0xFFFF, 0x0000 … 0x000D.
- Snapshot and ignore:
  - change the register-file contents of v3 from cycle 2 onward -> written data unchanged
  - `start` pulses in cycles 5 and 18 -> ignored, single `done`.
- Reset abort: `rst_n` low in cycle 9 -> all outputs 0 immediately, no `done`; a new start after release runs a clean 19-cycle store.
- With `VST_STRIDE_EN`, stride 4, base 0x0100 -> addresses 0x0100, 0x0104 … 0x013C.
